// File: rtl/oxide_rb_pkg.sv
// Shared types for the flip-flop readback block: FSM states and serial bit-order constants.
// The PAR state exists only when OXIDE_FF_READBACK_PARITY_EN is defined.
package oxide_rb_pkg;

`ifdef OXIDE_FF_READBACK_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } rb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd3
  } rb_state_e;
`endif

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/oxide_rb_shreg.sv
// Loadable shadow shift register; the head bit (next to leave) is bit 0 or bit WIDTH-1.
// Exposes the head of the next-state value so the parent can register SDO alongside it.
module oxide_rb_shreg
  import oxide_rb_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic             muxclk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             head_nxt_c
);

  localparam int unsigned HEAD = (MSB_FIRST == ORDER_MSB_FIRST) ? WIDTH - 1 : 0;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;

  // Load wins over shift; shift moves the next bit into the head position.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = d;
    end else if (shift) begin
      if (MSB_FIRST == ORDER_MSB_FIRST) nxt = {q[WIDTH-2:0], 1'b0};
      else                              nxt = {1'b0, q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge muxclk) begin
    if (rst) q <= '0;
    else     q <= nxt;
  end

  assign head_nxt_c = nxt[HEAD];

endmodule

// File: rtl/oxide_ff_readback.sv
// Serial readback of a flip-flop bank: captures Q_IN on REQ and shifts it out with SRDY handshake.
// Define OXIDE_FF_READBACK_PARITY_EN to append an even-parity bit to every frame.
module oxide_ff_readback
  import oxide_rb_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic [WIDTH-1:0] Q_IN,
  input  logic             REQ,
  input  logic             ABORT,
  input  logic             SRDY,
  output logic             SDO,
  output logic             SVALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rb_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_c, shift_c, head_nxt_c;
  logic          sdo_d, svalid_d, done_d;
`ifdef OXIDE_FF_READBACK_PARITY_EN
  logic          par_q, par_d;
`endif

  oxide_rb_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .muxclk     (CLK),
    .rst        (LSR),
    .load       (load_c),
    .shift      (shift_c),
    .d          (Q_IN),
    .head_nxt_c (head_nxt_c)
  );

  // Next state, counter and shadow control; ABORT beats a same-cycle transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
`ifdef OXIDE_FF_READBACK_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef OXIDE_FF_READBACK_PARITY_EN
          par_d   = ^Q_IN;
`endif
        end
      end
      SHIFT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (SRDY) begin
          shift_c = 1'b1;
          if (cnt_q == LAST) begin
`ifdef OXIDE_FF_READBACK_PARITY_EN
            state_d = PAR;
`else
            state_d = FIN;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef OXIDE_FF_READBACK_PARITY_EN
      PAR: begin
        if (ABORT)     state_d = IDLE;
        else if (SRDY) state_d = FIN;
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    sdo_d    = 1'b0;
    svalid_d = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      SHIFT: begin
        svalid_d = 1'b1;
        sdo_d    = head_nxt_c;
      end
`ifdef OXIDE_FF_READBACK_PARITY_EN
      PAR: begin
        svalid_d = 1'b1;
        sdo_d    = par_d;
      end
`endif
      FIN:     done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (LSR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      SDO     <= 1'b0;
      SVALID  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef OXIDE_FF_READBACK_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      SDO     <= sdo_d;
      SVALID  <= svalid_d;
      BUSY    <= svalid_d;
      DONE    <= done_d;
`ifdef OXIDE_FF_READBACK_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_oxide_ff_readback.sv
// Bench for oxide_ff_readback: LSB-first and MSB-first instances share stimulus and are
// checked against a bit-list model of each frame; honours OXIDE_FF_READBACK_PARITY_EN.
module tb_oxide_ff_readback;

`ifdef OXIDE_FF_READBACK_PARITY_EN
  localparam int FLEN = 17;
`else
  localparam int FLEN = 16;
`endif
  localparam int BUDGET = 200;

  logic        CLK = 1'b0;
  logic        LSR, REQ, ABORT, SRDY;
  logic [15:0] Q_IN;
  logic        sdo0, sv0, busy0, done0;
  logic        sdo1, sv1, busy1, done1;
  logic [7:0]  obs;

  int checks = 0;
  int errors = 0;
  bit e0[$];
  bit e1[$];

  always #5 CLK = ~CLK;

  oxide_ff_readback #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .LSR(LSR), .Q_IN(Q_IN), .REQ(REQ), .ABORT(ABORT), .SRDY(SRDY),
    .SDO(sdo0), .SVALID(sv0), .BUSY(busy0), .DONE(done0)
  );

  oxide_ff_readback #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(CLK), .LSR(LSR), .Q_IN(Q_IN), .REQ(REQ), .ABORT(ABORT), .SRDY(SRDY),
    .SDO(sdo1), .SVALID(sv1), .BUSY(busy1), .DONE(done1)
  );

  assign obs = {sdo0, sv0, busy0, done0, sdo1, sv1, busy1, done1};

  // Expected serial streams for a captured word, in each bit order.
  task automatic build_exp(input logic [15:0] v);
    e0.delete();
    e1.delete();
    for (int i = 0; i < 16; i++) begin
      e0.push_back(v[i]);
      e1.push_back(v[15-i]);
    end
`ifdef OXIDE_FF_READBACK_PARITY_EN
    e0.push_back(bit'($countones(v) % 2));
    e1.push_back(bit'($countones(v) % 2));
`endif
  endtask

  function automatic logic [7:0] in_frame(input int idx);
    return {e0[idx], 3'b110, e1[idx], 3'b110};
  endfunction

  task automatic test_reset();
    LSR = 1'b1; REQ = 1'b0; ABORT = 1'b0; SRDY = 1'b0; Q_IN = 16'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset cycle%0d obs=%b exp=%b", c, obs, 8'h00);
      end
    end
    LSR = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, 8'h00);
    end
  endtask

  // Modes: 0 full rate, 1 SRDY 1,0,0,1 with Q_IN zeroed mid-frame, 2 random SRDY and Q_IN.
  task automatic test_frames();
    logic [15:0] v;
    int mode, idx, cyc;
    for (int f = 0; f < 9; f++) begin
      v = (f == 0) ? 16'hA5C3 : 16'($urandom);
      mode = f % 3;
      build_exp(v);
      Q_IN = v; REQ = 1'b1;
      @(posedge CLK); @(negedge CLK);
      REQ = 1'b0;
      idx = 0; cyc = 0;
      while (idx < FLEN && cyc < BUDGET) begin
        checks++;
        if (obs !== in_frame(idx)) begin
          errors++;
          $display("FAIL frame%0d mode%0d bit%0d obs=%b exp=%b", f, mode, idx, obs, in_frame(idx));
        end
        case (mode)
          0:       SRDY = 1'b1;
          1:       SRDY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: SRDY = 1'($urandom);
        endcase
        if (mode == 1 && cyc == 6) Q_IN = 16'h0000;
        if (mode == 2) Q_IN = 16'($urandom);
        @(posedge CLK);
        if (SRDY) idx++;
        @(negedge CLK);
        cyc++;
      end
      checks++;
      if (idx < FLEN) begin
        errors++;
        $display("FAIL frame%0d timeout transfers=%0d required=%0d", f, idx, FLEN);
      end
      SRDY = 1'b0;
      checks++;
      if (obs !== 8'b0001_0001) begin
        errors++;
        $display("FAIL frame%0d fin obs=%b exp=%b", f, obs, 8'b0001_0001);
      end
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL frame%0d idle_after obs=%b exp=%b", f, obs, 8'h00);
      end
    end
  endtask

  // Abort after k transfers (k = FLEN-1 lands in the last data/parity slot); then restart.
  task automatic test_abort();
    int pts [3];
    logic [15:0] v;
    pts[0] = 5; pts[1] = FLEN - 1; pts[2] = $urandom_range(1, FLEN - 2);
    for (int a = 0; a < 3; a++) begin
      v = 16'($urandom);
      build_exp(v);
      Q_IN = v; REQ = 1'b1; SRDY = 1'b1;
      @(posedge CLK); @(negedge CLK);
      REQ = 1'b0;
      for (int k = 0; k < pts[a]; k++) begin
        checks++;
        if (obs !== in_frame(k)) begin
          errors++;
          $display("FAIL abort%0d bit%0d obs=%b exp=%b", a, k, obs, in_frame(k));
        end
        @(posedge CLK); @(negedge CLK);
      end
      ABORT = 1'b1;
      @(posedge CLK); @(negedge CLK);
      ABORT = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs !== 8'h00) begin
          errors++;
          $display("FAIL abort%0d after cycle%0d obs=%b exp=%b", a, c, obs, 8'h00);
        end
        ABORT = (c == 1);
        @(posedge CLK); @(negedge CLK);
      end
      ABORT = 1'b0;
    end
    v = 16'($urandom);
    build_exp(v);
    Q_IN = v; REQ = 1'b1;
    @(posedge CLK); @(negedge CLK);
    REQ = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      checks++;
      if (obs !== in_frame(k)) begin
        errors++;
        $display("FAIL abort_restart bit%0d obs=%b exp=%b", k, obs, in_frame(k));
      end
      @(posedge CLK); @(negedge CLK);
    end
    checks++;
    if (obs !== 8'b0001_0001) begin
      errors++;
      $display("FAIL abort_restart fin obs=%b exp=%b", obs, 8'b0001_0001);
    end
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic test_lsr_midframe();
    logic [15:0] v;
    v = 16'($urandom);
    build_exp(v);
    Q_IN = v; REQ = 1'b1; SRDY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    REQ = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); @(negedge CLK);
    end
    LSR = 1'b1; REQ = 1'b1; ABORT = 1'b1; Q_IN = ~v;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL lsr cycle%0d obs=%b exp=%b", c, obs, 8'h00);
      end
    end
    LSR = 1'b0; REQ = 1'b0; ABORT = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL lsr_no_capture obs=%b exp=%b", obs, 8'h00);
    end
    v = 16'($urandom);
    build_exp(v);
    Q_IN = v; REQ = 1'b1;
    @(posedge CLK); @(negedge CLK);
    REQ = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      checks++;
      if (obs !== in_frame(k)) begin
        errors++;
        $display("FAIL lsr_fresh bit%0d obs=%b exp=%b", k, obs, in_frame(k));
      end
      @(posedge CLK); @(negedge CLK);
    end
    checks++;
    if (obs !== 8'b0001_0001) begin
      errors++;
      $display("FAIL lsr_fresh fin obs=%b exp=%b", obs, 8'b0001_0001);
    end
    @(posedge CLK); @(negedge CLK);
  endtask

  // REQ held high: each frame takes Q_IN at its own capture edge, one IDLE cycle between frames.
  task automatic test_back_to_back();
    logic [15:0] v;
    v = 16'($urandom);
    build_exp(v);
    Q_IN = v; REQ = 1'b1; SRDY = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(posedge CLK); @(negedge CLK);
      for (int k = 0; k < FLEN; k++) begin
        checks++;
        if (obs !== in_frame(k)) begin
          errors++;
          $display("FAIL b2b frame%0d bit%0d obs=%b exp=%b", f, k, obs, in_frame(k));
        end
        Q_IN = 16'($urandom);
        @(posedge CLK); @(negedge CLK);
      end
      checks++;
      if (obs !== 8'b0001_0001) begin
        errors++;
        $display("FAIL b2b frame%0d fin obs=%b exp=%b", f, obs, 8'b0001_0001);
      end
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL b2b frame%0d gap obs=%b exp=%b", f, obs, 8'h00);
      end
      v = 16'($urandom);
      build_exp(v);
      Q_IN = v;
    end
    REQ = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL b2b release obs=%b exp=%b", obs, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_abort();
    test_lsr_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oxide_ff_readback.md
OXIDE_FF_READBACK -- requirements
Module: oxide_ff_readback

Interface
REQ-001 Parameter: WIDTH, default 16, number of flip-flop Q bits captured per frame (WIDTH >= 2).
REQ-002 Parameter: MSB_FIRST, default 0, serial bit order (0 = bit 0 first, 1 = bit WIDTH-1 first).
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 LSR  input  1  reset, synchronous, active-high.
REQ-005 Q_IN  input  WIDTH  parallel Q outputs of the flip-flop bank being read back.
REQ-006 REQ  input  1  start-of-readback request, sampled only in IDLE.
REQ-007 ABORT  input  1  synchronous frame abort.
REQ-008 SRDY  input  1  downstream ready for the serial bit.
REQ-009 SDO  output  1  serial data bit.
REQ-010 SVALID  output  1  SDO holds a valid bit.
REQ-011 BUSY  output  1  frame in progress.
REQ-012 DONE  output  1  single-cycle frame-complete pulse.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, PAR, FIN; IDLE on reset.
REQ-014 In IDLE, REQ=1 at an edge SHALL load shadow <= Q_IN, bit counter <= 0, parity <= XOR of Q_IN, and move to SHIFT; capture latency = 1 clock from REQ to first SVALID.
REQ-015 In SHIFT and PAR, SVALID and BUSY SHALL be 1; in IDLE and FIN, SVALID and BUSY SHALL be 0.
REQ-016 In SHIFT, SDO SHALL be shadow[0] (MSB_FIRST=0) or shadow[WIDTH-1] (MSB_FIRST=1).
REQ-017 A bit transfer SHALL occur only on an edge with SVALID=1 and SRDY=1; shadow shifts by one and the counter increments; SDO and SVALID remain stable while SRDY=0.
REQ-018 Transfer with counter = WIDTH-1 SHALL move to PAR if parity is compiled in, else to FIN.
REQ-019 In PAR, SDO SHALL equal the stored even-parity bit; transfer moves to FIN.
REQ-020 FIN SHALL last exactly one cycle with DONE=1, then return to IDLE.
REQ-021 SDO SHALL be 0 whenever SVALID=0.
REQ-022 REQ in SHIFT, PAR or FIN SHALL be ignored (no recapture, no queuing).
REQ-023 ABORT=1 in SHIFT or PAR SHALL return to IDLE next cycle without DONE; ABORT has priority over a simultaneous transfer; ABORT in IDLE or FIN has no effect.
REQ-024 Counter width SHALL be $clog2(WIDTH); no wrap past WIDTH-1.
REQ-025 Q_IN changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-026 LSR=1 SHALL force IDLE, shadow = 0, counter = 0, parity = 0, SDO = 0, SVALID = 0, BUSY = 0, DONE = 0 at the next edge.
REQ-027 LSR SHALL take priority over REQ, ABORT and SRDY, including mid-frame; no DONE is produced for a frame cut by reset.

Configuration
REQ-028 Macro OXIDE_FF_READBACK_PARITY_EN defined: PAR state present, frame = WIDTH+1 transfers.
REQ-029 Macro undefined: PAR state, parity register and XOR tree absent; frame = WIDTH transfers, SHIFT goes directly to FIN.

Structure
REQ-030 Package oxide_rb_pkg SHALL hold the FSM state typedef and the bit-order constants.
REQ-031 One sub-module oxide_rb_shreg (WIDTH-bit loadable shift register with direction select) SHALL hold the shadow register; FSM and counter stay in the top.

Verification
REQ-032 WIDTH=16, MSB_FIRST=0, Q_IN=16'hA5C3, REQ pulse, SRDY=1 -> SDO sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, parity bit 0 (macro on), DONE one cycle after last transfer.
REQ-033 Same Q_IN, MSB_FIRST=1 -> SDO sequence starts 1,0,1,0; 16 data transfers total.
REQ-034 SRDY toggled 1,0,0,1 every 4 cycles -> SDO/SVALID stable during SRDY=0, no bit lost or repeated, Q_IN changed to 16'h0000 mid-frame has no effect.
REQ-035 ABORT asserted after 5 transfers with SRDY=1 -> IDLE next cycle, BUSY=0, DONE never asserted; next REQ restarts from bit 0.
REQ-036 LSR asserted mid-frame together with REQ -> all outputs 0, IDLE, no capture; REQ after LSR release starts a fresh frame.
REQ-037 REQ held high continuously -> frames back to back with exactly one IDLE cycle between FIN and next capture; macro off -> no parity bit in any frame.
